// File: rtl/fb_scanout.sv
// fb_scanout: 640x480@60 VGA scanout of a 320x240 12-bit frame buffer,
// upscaled 2x in both axes. Reads a synchronous BRAM port one pixel tick
// at a time, aligns syncs/DE/vblank with the returned colour, and exports
// vblank and a frame-start pulse for the rest of the system.
// Optional feature: define FB_SCANOUT_YFLIP_EN to treat frame-buffer row 0
// as the bottom display line (Y-up rasterizer).
module fb_scanout #(
  parameter int H_ACTIVE = 640,
  parameter int H_FP     = 16,
  parameter int H_SYNC   = 96,
  parameter int H_BP     = 48,
  parameter int V_ACTIVE = 480,
  parameter int V_FP     = 10,
  parameter int V_SYNC   = 2,
  parameter int V_BP     = 33,
  parameter int CLK_DIV  = 4,
  parameter int FB_W     = 320,
  parameter int FB_H     = 240
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        i_enable,
  output logic [16:0] o_fb_addr,
  output logic        o_fb_re,
  input  logic [11:0] i_fb_data,
  output logic        o_hsync,
  output logic        o_vsync,
  output logic [3:0]  o_r,
  output logic [3:0]  o_g,
  output logic [3:0]  o_b,
  output logic        o_de,
  output logic        o_vblank,
  output logic        o_frame_start
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int HW = $clog2(H_TOTAL);
  localparam int VW = $clog2(V_TOTAL);
  localparam int DW = $clog2(CLK_DIV);

  localparam logic [HW-1:0] H_LAST = HW'(H_TOTAL - 1);
  localparam logic [HW-1:0] H_ACT  = HW'(H_ACTIVE);
  localparam logic [HW-1:0] HS_BEG = HW'(H_ACTIVE + H_FP);
  localparam logic [HW-1:0] HS_END = HW'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [VW-1:0] V_LAST = VW'(V_TOTAL - 1);
  localparam logic [VW-1:0] V_ACT  = VW'(V_ACTIVE);
  localparam logic [VW-1:0] V_ACT_M1 = VW'(V_ACTIVE - 1);
  localparam logic [VW-1:0] VS_BEG = VW'(V_ACTIVE + V_FP);
  localparam logic [VW-1:0] VS_END = VW'(V_ACTIVE + V_FP + V_SYNC);
  localparam logic [DW-1:0] DIV_LAST = DW'(CLK_DIV - 1);
  localparam logic [16:0]   FB_STEP  = 17'(FB_W);
`ifdef FB_SCANOUT_YFLIP_EN
  localparam logic [16:0]   RB_INIT  = 17'((FB_H - 1) * FB_W);
`else
  localparam logic [16:0]   RB_INIT  = 17'd0;
`endif

  // Video side-band bundle {de, hsync_n, vsync_n, vblank}; idle = blanked.
  localparam logic [3:0] VID_IDLE = 4'b0111;

  logic [DW-1:0] div_q, div_d;
  logic [HW-1:0] hcnt_q, hcnt_d;
  logic [VW-1:0] vcnt_q, vcnt_d;
  logic [16:0]   rb_q, rb_d;
  logic [16:0]   addr_q, addr_d;
  logic          re_q, re_d;
  logic          re1_q, re1_d;
  logic          fs_q, fs_d;
  logic [3:0]    vid0_q, vid0_d, vid1_q, vid1_d, vid2_q, vid2_d;
  logic [11:0]   rgb_q, rgb_d;

  logic tick, active, hs_n, vs_n, vb;

  assign tick   = (div_q == '0);
  assign active = (hcnt_q < H_ACT) && (vcnt_q < V_ACT);
  assign hs_n   = !((hcnt_q >= HS_BEG) && (hcnt_q < HS_END));
  assign vs_n   = !((vcnt_q >= VS_BEG) && (vcnt_q < VS_END));
  assign vb     = (vcnt_q >= V_ACT);

  // Next state: timing counters, row accumulator, read strobe and the
  // two-stage delay that lines side-band signals up with returned data.
  always_comb begin
    div_d  = (div_q == DIV_LAST) ? '0 : div_q + 1'b1;
    hcnt_d = hcnt_q;
    vcnt_d = vcnt_q;
    rb_d   = rb_q;
    addr_d = addr_q;
    re_d   = tick && active;
    fs_d   = tick && (hcnt_q == '0) && (vcnt_q == '0);
    vid0_d = vid0_q;
    vid1_d = vid0_q;
    vid2_d = vid1_q;
    re1_d  = re_q;
    // Load on returned data; hold through the rest of an active pixel;
    // zero as soon as the aligned pixel is blank.
    rgb_d  = re1_q ? i_fb_data : (vid1_q[3] ? rgb_q : 12'd0);
    if (tick) begin
      vid0_d = {active, hs_n, vs_n, vb};
      if (active) addr_d = rb_q + 17'(hcnt_q >> 1);
      if (hcnt_q == H_LAST) begin
        hcnt_d = '0;
        if (vcnt_q == V_LAST) begin
          vcnt_d = '0;
          rb_d   = RB_INIT;
        end else begin
          vcnt_d = vcnt_q + 1'b1;
          // Advance one source row after every odd display line; the last
          // visible line is skipped so the accumulator stays in range.
          if (vcnt_q[0] && (vcnt_q < V_ACT_M1)) begin
`ifdef FB_SCANOUT_YFLIP_EN
            rb_d = rb_q - FB_STEP;
`else
            rb_d = rb_q + FB_STEP;
`endif
          end
        end
      end else begin
        hcnt_d = hcnt_q + 1'b1;
      end
    end
    // Disabled: everything parks at the origin with outputs idle, so the
    // next enabled clk is the first tick of a fresh frame.
    if (!i_enable) begin
      div_d  = '0;
      hcnt_d = '0;
      vcnt_d = '0;
      rb_d   = RB_INIT;
      addr_d = '0;
      re_d   = 1'b0;
      re1_d  = 1'b0;
      fs_d   = 1'b0;
      vid0_d = VID_IDLE;
      vid1_d = VID_IDLE;
      vid2_d = VID_IDLE;
      rgb_d  = '0;
    end
  end

  // State and output registers with asynchronous reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div_q  <= '0;
      hcnt_q <= '0;
      vcnt_q <= '0;
      rb_q   <= RB_INIT;
      addr_q <= '0;
      re_q   <= 1'b0;
      re1_q  <= 1'b0;
      fs_q   <= 1'b0;
      vid0_q <= VID_IDLE;
      vid1_q <= VID_IDLE;
      vid2_q <= VID_IDLE;
      rgb_q  <= '0;
    end else begin
      div_q  <= div_d;
      hcnt_q <= hcnt_d;
      vcnt_q <= vcnt_d;
      rb_q   <= rb_d;
      addr_q <= addr_d;
      re_q   <= re_d;
      re1_q  <= re1_d;
      fs_q   <= fs_d;
      vid0_q <= vid0_d;
      vid1_q <= vid1_d;
      vid2_q <= vid2_d;
      rgb_q  <= rgb_d;
    end
  end

  assign o_fb_addr     = addr_q;
  assign o_fb_re       = re_q;
  assign o_frame_start = fs_q;
  assign o_de          = vid2_q[3];
  assign o_hsync       = vid2_q[2];
  assign o_vsync       = vid2_q[1];
  assign o_vblank      = vid2_q[0];
  assign o_r           = rgb_q[11:8];
  assign o_g           = rgb_q[7:4];
  assign o_b           = rgb_q[3:0];

endmodule

// File: doc/fb_scanout.md
# fb_scanout

Display-side reader of the 320x240 12-bit frame buffer that the rasterizer writes. Generates 640x480@60 VGA timing from the 100 MHz system clock, issues synchronous-read addresses to the frame-buffer BRAM read port, upscales 2x in both axes and drives 4:4:4 RGB plus syncs. Exports vblank and frame-start so `fpga_top` can gate rasterizer starts and frame-buffer clears to the blanking interval.

## Interface
- `H_ACTIVE`, 640, visible pixels per line
- `H_FP` / `H_SYNC` / `H_BP`, 16 / 96 / 48, horizontal porch and sync widths in pixel ticks
- `V_ACTIVE`, 480, visible lines
- `V_FP` / `V_SYNC` / `V_BP`, 10 / 2 / 33, vertical porch and sync widths in lines
- `CLK_DIV`, 4, clk cycles per pixel tick; must be ≥3
- `FB_W` / `FB_H`, 320 / 240, frame-buffer dimensions (H_ACTIVE = 2·FB_W, V_ACTIVE = 2·FB_H)
- `clk`  in  1  system clock, 100 MHz
- `rst_n`  in  1  asynchronous, active-low reset
- `i_enable`  in  1  run scanout; low holds timing at origin
- `o_fb_addr`  out  17  frame-buffer read address, row-major, `y*FB_W+x`
- `o_fb_re`  out  1  one-clk read strobe
- `i_fb_data`  in  12  read data {R[11:8],G[7:4],B[3:0]}, valid one clk after `o_fb_re`
- `o_hsync`, `o_vsync`  out  1  active-low syncs
- `o_r`, `o_g`, `o_b`  out  4  pixel colour, zero outside active area
- `o_de`  out  1  active-video flag
- `o_vblank`  out  1  high while line counter ≥ V_ACTIVE
- `o_frame_start`  out  1  one-clk pulse at start of each frame

## Operation
- Tick divider counts 0..CLK_DIV-1; pixel tick asserted when divider = 0.
- On each tick: `hcnt` advances 0..799, wrapping to 0 and advancing `vcnt` 0..524, which wraps to 0.
- Active iff `hcnt < H_ACTIVE && vcnt < V_ACTIVE`. Sync low during `[ACTIVE+FP, ACTIVE+FP+SYNC)` on each axis.
- On a tick in the active area: `o_fb_re`=1 for that one clk, `o_fb_addr = row_base + (hcnt>>1)`.
- `row_base` is an accumulator, not a multiplier:
  - cleared at `vcnt` wrap
  - incremented by FB_W when a line with odd `vcnt` ends
  - each source row is therefore read for two display lines; each source pixel for two ticks.
- `i_fb_data` is captured the clk after the strobe. RGB outputs are loaded on the following clk.
- Unused ticks (blanking) issue no read; RGB forced to 0.
- `o_frame_start` pulses on the tick where `hcnt` and `vcnt` both wrap to 0.
- `i_enable` low:
  - divider, counters and `row_base` held at 0
  - `o_fb_re`=0, syncs high, RGB 0, `o_de`=0, `o_vblank`=1
- Rising `i_enable` starts a fresh frame with `o_frame_start`.

## Timing
- Reset values (async on `rst_n` low): `o_fb_addr`=0, `o_fb_re`=0, `o_hsync`=1, `o_vsync`=1, RGB=0, `o_de`=0, `o_vblank`=1, `o_frame_start`=0, all counters 0.
- Latency: tick clk T drives address/strobe; data arrives at T+1; RGB, `o_de`, `o_hsync`, `o_vsync` and `o_vblank` are all registered at T+2.
  - Sync, DE and vblank pass through a 2-stage delay so every video output is aligned.
- `o_frame_start` is undelayed: it fires at T, one clk before the first address's data returns.
- Line period 800·CLK_DIV = 3200 clk; frame period 525·3200 = 1,680,000 clk.
- Reset asserted mid-frame: immediate return to reset values, with no partial-line continuation. First read after release occurs at `hcnt`=0, `vcnt`=0.
- `i_enable` falling mid-line: same as reset on the next clk, except that the read-data capture register may complete one pending capture, which is discarded.
- Last address of a frame is 76799; `row_base` never exceeds 76480.

## Configuration
- `FB_SCANOUT_YFLIP_EN` defined:
  - row 0 of the frame buffer is the bottom display line (rasterizer uses Y-up)
  - `row_base` starts at (FB_H-1)·FB_W = 76480 and decrements by FB_W
- Undefined: row 0 is the top line; `row_base` starts at 0 and increments.

## Test plan
- Reset release with `i_enable`=1, run one frame:
  - `o_hsync` low exactly 384 clk per line
  - `o_vsync` low exactly 6400 clk
  - `o_frame_start` spacing 1,680,000 clk
- Frame buffer preloaded with address-pattern data:
  - display (0,0) reads addr 0; (639,479) reads 76799
  - each address is read on exactly 4 ticks per frame
  - no read during blanking
- Set fb[5]=12'hABC. At display h=10 and h=11 on v=0 and v=1, outputs are R=A G=B B=C with `o_de`=1, two clk after the corresponding strobe.
- With `FB_SCANOUT_YFLIP_EN`: display (0,0) reads 76480, and display (0,479) reads 0.
- Drop `i_enable` at `vcnt`=100, `hcnt`=300, hold 50 clk, then re-raise:
  - outputs idle while low and `o_vblank`=1
  - on re-raise, `o_frame_start` fires and the next read is addr 0
- Pulse `rst_n` low mid-line:
  - all outputs take reset values asynchronously within the same clk
  - timing restarts from the origin
